// File: rtl/axi4_stream_pkt_defrag.sv
// Reassembles EOP-delimited AXI4-Stream fragments into contiguous packets with byte realignment.
// Optional per-packet byte counter: define AXI4_STREAM_PKT_DEFRAG_CNT_EN.
module axi4_stream_pkt_defrag #(
    parameter int unsigned TDATA_WIDTH   = 64,
    parameter int unsigned TID_WIDTH     = 1,
    parameter int unsigned TDEST_WIDTH   = 1,
    parameter int unsigned TUSER_WIDTH   = 1,
    parameter int unsigned EOP_TUSER_BIT = 0,
    parameter int unsigned MAX_PKT_SIZE  = 65536
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
    output logic [$clog2(MAX_PKT_SIZE):0] pkt_bytes_o,
    output logic                          pkt_bytes_valid_o,
`endif
    input  logic                          pkt_i_tvalid,
    output logic                          pkt_i_tready,
    input  logic [TDATA_WIDTH-1:0]        pkt_i_tdata,
    input  logic [TDATA_WIDTH/8-1:0]      pkt_i_tkeep,
    input  logic [TDATA_WIDTH/8-1:0]      pkt_i_tstrb,
    input  logic                          pkt_i_tlast,
    input  logic [TID_WIDTH-1:0]          pkt_i_tid,
    input  logic [TDEST_WIDTH-1:0]        pkt_i_tdest,
    input  logic [TUSER_WIDTH-1:0]        pkt_i_tuser,
    output logic                          pkt_o_tvalid,
    input  logic                          pkt_o_tready,
    output logic [TDATA_WIDTH-1:0]        pkt_o_tdata,
    output logic [TDATA_WIDTH/8-1:0]      pkt_o_tkeep,
    output logic [TDATA_WIDTH/8-1:0]      pkt_o_tstrb,
    output logic                          pkt_o_tlast,
    output logic [TID_WIDTH-1:0]          pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]        pkt_o_tdest,
    output logic [TUSER_WIDTH-1:0]        pkt_o_tuser
);

    localparam int unsigned TDATA_WIDTH_B = TDATA_WIDTH / 8;
    localparam int unsigned BUF_B         = 2 * TDATA_WIDTH_B;
    localparam int unsigned CNT_W         = $clog2(BUF_B + 1);
    localparam int unsigned IW            = CNT_W + 1;
    localparam int unsigned IDX_W         = $clog2(BUF_B);
    localparam int unsigned KIDX_W        = (TDATA_WIDTH_B > 1) ? $clog2(TDATA_WIDTH_B) : 1;
    localparam logic [CNT_W-1:0] BEAT_B   = CNT_W'(TDATA_WIDTH_B);

    if (TDATA_WIDTH % 8 != 0) begin : g_chk_width
        $error("TDATA_WIDTH must be a multiple of 8");
    end
    if (EOP_TUSER_BIT >= TUSER_WIDTH) begin : g_chk_eop
        $error("EOP_TUSER_BIT must be below TUSER_WIDTH");
    end
    if (MAX_PKT_SIZE < TDATA_WIDTH_B) begin : g_chk_max
        $error("MAX_PKT_SIZE must hold at least one beat");
    end

    logic [7:0]             buf_data_q [BUF_B];
    logic [7:0]             buf_data_d [BUF_B];
    logic [BUF_B-1:0]       buf_strb_q, buf_strb_d;
    logic [CNT_W-1:0]       bytes_in_buf_q, bytes_in_buf_d;
    logic                   flush_q, first_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic [TDEST_WIDTH-1:0] tdest_q;
    logic [TUSER_WIDTH-1:0] tuser_q;

    logic [7:0]             in_bytes [TDATA_WIDTH_B];
    logic [IW-1:0]          src_idx [BUF_B];
    logic [IW-1:0]          wr_off [BUF_B];
    logic [CNT_W-1:0]       rx_bytes, tx_bytes, tx_shift, wr_base;
    logic                   rx_fire, tx_fire, eop_beat, zero_len;

    always_comb begin
        rx_bytes = '0;
        for (int i = 0; i < TDATA_WIDTH_B; i++) begin
            rx_bytes    = rx_bytes + CNT_W'(pkt_i_tkeep[i]);
            in_bytes[i] = pkt_i_tdata[i*8 +: 8];
        end
    end

    assign tx_bytes     = (bytes_in_buf_q >= BEAT_B) ? BEAT_B : bytes_in_buf_q;
    assign pkt_i_tready = (bytes_in_buf_q <= BEAT_B) && !flush_q;
    assign pkt_o_tvalid = (bytes_in_buf_q >= BEAT_B) || (flush_q && (bytes_in_buf_q != '0));
    assign pkt_o_tlast  = flush_q && (bytes_in_buf_q == tx_bytes);
    assign pkt_o_tid    = tid_q;
    assign pkt_o_tdest  = tdest_q;
    assign pkt_o_tuser  = tuser_q;

    assign rx_fire  = pkt_i_tvalid && pkt_i_tready;
    assign tx_fire  = pkt_o_tvalid && pkt_o_tready;
    assign eop_beat = pkt_i_tlast && pkt_i_tuser[EOP_TUSER_BIT];
    // An EOP carrying no bytes onto an empty buffer is a zero-length packet and is dropped.
    assign zero_len = eop_beat && (rx_bytes == '0) && (bytes_in_buf_q == '0);

    assign tx_shift       = tx_fire ? tx_bytes : '0;
    assign wr_base        = bytes_in_buf_q - tx_shift;
    assign bytes_in_buf_d = wr_base + (rx_fire ? rx_bytes : '0);

    always_comb begin
        pkt_o_tkeep = '0;
        pkt_o_tdata = '0;
        for (int i = 0; i < TDATA_WIDTH_B; i++) begin
            pkt_o_tkeep[i]       = CNT_W'(i) < tx_bytes;
            pkt_o_tdata[i*8 +: 8] = buf_data_q[i];
        end
        pkt_o_tstrb = buf_strb_q[TDATA_WIDTH_B-1:0] & pkt_o_tkeep;
    end

    // Departing bytes shift the buffer down; arriving bytes land right after what remains.
    always_comb begin
        for (int j = 0; j < BUF_B; j++) begin
            src_idx[j]    = IW'(j) + IW'(tx_shift);
            wr_off[j]     = IW'(j) - IW'(wr_base);
            buf_data_d[j] = '0;
            buf_strb_d[j] = 1'b0;
            if (src_idx[j] < IW'(BUF_B)) begin
                buf_data_d[j] = buf_data_q[src_idx[j][IDX_W-1:0]];
                buf_strb_d[j] = buf_strb_q[src_idx[j][IDX_W-1:0]];
            end
            if (rx_fire && (IW'(j) >= IW'(wr_base)) && (wr_off[j] < IW'(rx_bytes))) begin
                buf_data_d[j] = in_bytes[wr_off[j][KIDX_W-1:0]];
                buf_strb_d[j] = pkt_i_tstrb[wr_off[j][KIDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < BUF_B; j++) begin
                buf_data_q[j] <= '0;
            end
            buf_strb_q     <= '0;
            bytes_in_buf_q <= '0;
            flush_q        <= 1'b0;
            first_q        <= 1'b1;
            tid_q          <= '0;
            tdest_q        <= '0;
            tuser_q        <= '0;
        end else begin
            for (int j = 0; j < BUF_B; j++) begin
                buf_data_q[j] <= buf_data_d[j];
            end
            buf_strb_q     <= buf_strb_d;
            bytes_in_buf_q <= bytes_in_buf_d;
            if (rx_fire) begin
                tuser_q <= pkt_i_tuser;
                if (first_q && !zero_len) begin
                    tid_q   <= pkt_i_tid;
                    tdest_q <= pkt_i_tdest;
                    first_q <= 1'b0;
                end
                if (eop_beat && !zero_len) begin
                    flush_q <= 1'b1;
                end
            end
            // rx is blocked while flushing, so this never collides with the set above.
            if (tx_fire && pkt_o_tlast) begin
                flush_q <= 1'b0;
                first_q <= 1'b1;
            end
        end
    end

`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
    localparam int unsigned PB_W = $clog2(MAX_PKT_SIZE) + 1;

    logic [PB_W-1:0] pkt_cnt_q, pkt_bytes_q, cnt_sum, cnt_sat;
    logic            pkt_bytes_valid_q;

    assign cnt_sum = pkt_cnt_q + PB_W'(tx_bytes);
    assign cnt_sat = (cnt_sum > PB_W'(MAX_PKT_SIZE)) ? PB_W'(MAX_PKT_SIZE) : cnt_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q         <= '0;
            pkt_bytes_q       <= '0;
            pkt_bytes_valid_q <= 1'b0;
        end else begin
            pkt_bytes_valid_q <= 1'b0;
            if (tx_fire) begin
                if (pkt_o_tlast) begin
                    pkt_bytes_q       <= cnt_sat;
                    pkt_bytes_valid_q <= 1'b1;
                    pkt_cnt_q         <= '0;
                end else begin
                    pkt_cnt_q <= cnt_sat;
                end
            end
        end
    end

    assign pkt_bytes_o       = pkt_bytes_q;
    assign pkt_bytes_valid_o = pkt_bytes_valid_q;
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_defrag.sv
// Directed bench for axi4_stream_pkt_defrag: byte-queue reference model checked every cycle,
// plus literal per-scenario beat expectations.
module tb_axi4_stream_pkt_defrag;

    localparam int B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_last;
    logic [63:0] in_data;
    logic [7:0]  in_keep, in_strb;
    logic [0:0]  in_tid, in_dest, in_user;
    logic        out_valid, out_ready, out_last;
    logic [63:0] out_data;
    logic [7:0]  out_keep, out_strb;
    logic [0:0]  out_tid, out_dest, out_user;
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
    logic [16:0] pkt_bytes;
    logic        pkt_bytes_valid;
    int          last_bytes = -1;
    bit          cnt_pend = 1'b0;
    int          cnt_exp = 0;
`endif

    axi4_stream_pkt_defrag #(
        .TDATA_WIDTH  (64),
        .TID_WIDTH    (1),
        .TDEST_WIDTH  (1),
        .TUSER_WIDTH  (1),
        .EOP_TUSER_BIT(0),
        .MAX_PKT_SIZE (65536)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
        .pkt_bytes_o      (pkt_bytes),
        .pkt_bytes_valid_o(pkt_bytes_valid),
`endif
        .pkt_i_tvalid     (in_valid),
        .pkt_i_tready     (in_ready),
        .pkt_i_tdata      (in_data),
        .pkt_i_tkeep      (in_keep),
        .pkt_i_tstrb      (in_strb),
        .pkt_i_tlast      (in_last),
        .pkt_i_tid        (in_tid),
        .pkt_i_tdest      (in_dest),
        .pkt_i_tuser      (in_user),
        .pkt_o_tvalid     (out_valid),
        .pkt_o_tready     (out_ready),
        .pkt_o_tdata      (out_data),
        .pkt_o_tkeep      (out_keep),
        .pkt_o_tstrb      (out_strb),
        .pkt_o_tlast      (out_last),
        .pkt_o_tid        (out_tid),
        .pkt_o_tdest      (out_dest),
        .pkt_o_tuser      (out_user)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout/missing, expected event (t=%0t)", name, $time);
    endtask

    // Reference model: the bytes accepted but not yet emitted, in order.
    logic [7:0] q_data[$];
    bit         q_strb[$];
    bit         flush_m = 1'b0;
    bit         first_m = 1'b1;
    logic [0:0] tid_m = '0, tdest_m = '0, tuser_m = '0;
    int         pkt_total_m = 0;

    logic [7:0]  log_keep[$];
    bit          log_last[$];
    logic [0:0]  log_tid[$];
    logic [63:0] log_data[$];

    int cyc = 0;
    int rx_cyc = 0;
    int vrise_cyc = 0;
    bit prev_valid = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int popc(input logic [7:0] k);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(k[i]);
        return c;
    endfunction

    always @(negedge clk) begin : mon
        int          buf0, n;
        bit          exp_valid, exp_last, eop;
        logic [63:0] exp_data, mask;
        logic [7:0]  exp_keep, exp_strb;
        if (rst) begin
            q_data.delete();
            q_strb.delete();
            flush_m     = 1'b0;
            first_m     = 1'b1;
            tid_m       = '0;
            tdest_m     = '0;
            tuser_m     = '0;
            pkt_total_m = 0;
            prev_valid  = 1'b0;
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
            cnt_pend = 1'b0;
`endif
        end else begin
            buf0 = q_data.size();
            check("in_tready", in_ready, (buf0 <= B) && !flush_m);
            exp_valid = (buf0 >= B) || (flush_m && buf0 > 0);
            check("out_tvalid", out_valid, exp_valid);
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
            check("pkt_bytes_valid", pkt_bytes_valid, cnt_pend);
            if (cnt_pend) check("pkt_bytes", pkt_bytes, cnt_exp);
            if (pkt_bytes_valid) last_bytes = int'(pkt_bytes);
            cnt_pend = 1'b0;
`endif
            if (out_valid && !prev_valid) vrise_cyc = cyc;
            prev_valid = out_valid;
            if (exp_valid) begin
                n = (buf0 < B) ? buf0 : B;
                exp_keep = '0;
                exp_strb = '0;
                exp_data = '0;
                mask = '0;
                for (int i = 0; i < n; i++) begin
                    exp_keep[i] = 1'b1;
                    exp_strb[i] = q_strb[i];
                    exp_data[i*8 +: 8] = q_data[i];
                    mask[i*8 +: 8] = 8'hFF;
                end
                exp_last = flush_m && (buf0 <= B);
                check("out_tkeep", out_keep, exp_keep);
                check("out_tstrb", out_strb, exp_strb);
                check("out_tlast", out_last, exp_last);
                check("out_tdata", out_data & mask, exp_data);
                check("out_tid", out_tid, tid_m);
                check("out_tdest", out_dest, tdest_m);
                check("out_tuser", out_user, tuser_m);
                if (out_valid && out_ready) begin
                    for (int i = 0; i < n; i++) begin
                        void'(q_data.pop_front());
                        void'(q_strb.pop_front());
                    end
                    pkt_total_m += n;
                    log_keep.push_back(out_keep);
                    log_last.push_back(out_last);
                    log_tid.push_back(out_tid);
                    log_data.push_back(out_data & mask);
                    if (exp_last) begin
                        flush_m = 1'b0;
                        first_m = 1'b1;
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
                        cnt_pend = 1'b1;
                        cnt_exp  = pkt_total_m;
`endif
                        pkt_total_m = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                n = popc(in_keep);
                rx_cyc = cyc;
                tuser_m = in_user;
                eop = in_last && in_user[0];
                if (!(eop && n == 0 && buf0 == 0)) begin
                    if (first_m) begin
                        tid_m   = in_tid;
                        tdest_m = in_dest;
                        first_m = 1'b0;
                    end
                    for (int i = 0; i < n; i++) begin
                        q_data.push_back(in_data[i*8 +: 8]);
                        q_strb.push_back(in_strb[i]);
                    end
                    if (eop) flush_m = 1'b1;
                end
            end
        end
    end

    logic [7:0] next_byte = 8'd1;

    task automatic send_beat(input int n, input bit last, input bit eop, input logic id);
        bit hs = 1'b0;
        int t = 0;
        in_data = {$urandom, $urandom};
        in_keep = '0;
        in_strb = 8'hFF;
        for (int i = 0; i < n; i++) begin
            in_keep[i] = 1'b1;
            in_data[i*8 +: 8] = next_byte;
            in_strb[i] = next_byte[0] ^ next_byte[3];
            next_byte = next_byte + 8'd1;
        end
        in_last  = last;
        in_user  = last && eop;
        in_tid   = id;
        in_dest  = ~id;
        in_valid = 1'b1;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            t++;
        end
        if (!hs) fail_now("rx_handshake_timeout");
        #1;
    endtask

    task automatic send_frag(input int nbytes, input bit eop, input logic id);
        int rem = nbytes;
        while (rem > B) begin
            send_beat(B, 1'b0, 1'b0, id);
            rem -= B;
        end
        send_beat(rem, 1'b1, eop, id);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = '0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q_data.size() != 0 || flush_m || out_valid) && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t >= 300) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string name, input int idx, input logic [7:0] keep,
                              input bit last, input logic tid);
        if (idx >= log_keep.size()) begin
            fail_now(name);
        end else begin
            check({name, "_keep"}, log_keep[idx], keep);
            check({name, "_last"}, log_last[idx], last);
            check({name, "_tid"}, log_tid[idx], tid);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_strb   = '0;
        in_last   = 1'b0;
        in_tid    = '0;
        in_dest   = '0;
        in_user   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_tvalid", out_valid, 0);
        check("rst_tready", in_ready, 1);
        check("rst_tkeep", out_keep, 0);
        check("rst_tstrb", out_strb, 0);
        check("rst_tlast", out_last, 0);
        check("rst_tdata", out_data, 0);
        check("rst_tid", out_tid, 0);
        check("rst_tuser", out_user, 0);
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
        check("rst_bytes_valid", pkt_bytes_valid, 0);
`endif
        @(posedge clk);
        #1;

        // 5+5+5 bytes, EOP on the third
        log_keep.delete(); log_last.delete(); log_tid.delete(); log_data.delete();
        send_frag(5, 1'b0, 1'b0);
        send_frag(5, 1'b0, 1'b0);
        send_frag(5, 1'b1, 1'b0);
        wait_drain();
        check("t1_beats", log_keep.size(), 2);
        check_beat("t1_b0", 0, 8'hFF, 1'b0, 1'b0);
        check_beat("t1_b1", 1, 8'h7F, 1'b1, 1'b0);
        if (log_data.size() == 2) begin
            check("t1_data0", log_data[0], 64'h0807060504030201);
            check("t1_data1", log_data[1], 64'h000F0E0D0C0B0A09);
        end else fail_now("t1_data");
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
        check("t1_pkt_bytes", last_bytes, 15);
`endif

        // single full-beat EOP fragment, latency of one cycle
        log_keep.delete(); log_last.delete(); log_tid.delete(); log_data.delete();
        send_frag(8, 1'b1, 1'b0);
        wait_drain();
        check("t2_beats", log_keep.size(), 1);
        check_beat("t2_b0", 0, 8'hFF, 1'b1, 1'b0);
        check("t2_latency", vrise_cyc - rx_cyc, 1);
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
        check("t2_pkt_bytes", last_bytes, 8);
`endif

        // 16 bytes then 3-byte EOP
        log_keep.delete(); log_last.delete(); log_tid.delete(); log_data.delete();
        send_frag(16, 1'b0, 1'b0);
        send_frag(3, 1'b1, 1'b0);
        wait_drain();
        check("t3_beats", log_keep.size(), 3);
        check_beat("t3_b0", 0, 8'hFF, 1'b0, 1'b0);
        check_beat("t3_b1", 1, 8'hFF, 1'b0, 1'b0);
        check_beat("t3_b2", 2, 8'h07, 1'b1, 1'b0);
        if (log_data.size() == 3) check("t3_data2", log_data[2], 64'h00000000002A2928);
        else fail_now("t3_data");

        // output stalled for 10 cycles during a 3-fragment packet
        log_keep.delete(); log_last.delete(); log_tid.delete(); log_data.delete();
        out_ready = 1'b0;
        fork
            begin
                send_frag(5, 1'b0, 1'b0);
                send_frag(5, 1'b0, 1'b0);
                send_frag(5, 1'b1, 1'b0);
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("t4_stall_tready", in_ready, 0);
                check("t4_stall_tvalid", out_valid, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("t4_beats", log_keep.size(), 2);
        check_beat("t4_b0", 0, 8'hFF, 1'b0, 1'b0);
        check_beat("t4_b1", 1, 8'h7F, 1'b1, 1'b0);
        if (log_data.size() == 2) begin
            check("t4_data0", log_data[0], 64'h3231302F2E2D2C2B);
            check("t4_data1", log_data[1], 64'h0039383736353433);
        end else fail_now("t4_data");

        // back-to-back packets A (3 B, tid 0) and B (9 B, tid 1)
        log_keep.delete(); log_last.delete(); log_tid.delete(); log_data.delete();
        send_frag(3, 1'b1, 1'b0);
        send_frag(9, 1'b1, 1'b1);
        wait_drain();
        check("t5_beats", log_keep.size(), 3);
        check_beat("t5_a0", 0, 8'h07, 1'b1, 1'b0);
        check_beat("t5_b0", 1, 8'hFF, 1'b0, 1'b1);
        check_beat("t5_b1", 2, 8'h01, 1'b1, 1'b1);

        // zero-length EOP, then reset in the middle of a packet
        log_keep.delete(); log_last.delete(); log_tid.delete(); log_data.delete();
        send_frag(0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_zero_len_beats", log_keep.size(), 0);
        send_frag(5, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_frag(4, 1'b1, 1'b1);
        wait_drain();
        check("t6_beats", log_keep.size(), 1);
        check_beat("t6_b0", 0, 8'h0F, 1'b1, 1'b1);
`ifdef AXI4_STREAM_PKT_DEFRAG_CNT_EN
        check("t6_pkt_bytes", last_bytes, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
